// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract sequencer: FSM encoding,
// operation-select constants and the default datapath width.
package addsub_pkg;

    localparam int W_DEFAULT = 4;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/addsub_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level debounce
// counter and a single-cycle press pulse on an accepted high-to-low change.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Bring the raw key into the clock domain; idle level is released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it differs from the debounced level for
    // DEBOUNCE_CYCLES consecutive cycles; pulse once on an accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/addsub_sequencer.sv
// Switch-driven add/subtract sequencer: debounced OP/GO keys, operand latch,
// iterative XOR/AND/shift carry-propagate adder and registered result/overflow.
module addsub_sequencer
    import addsub_pkg::*;
#(
    parameter int W               = W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         MODE,
    input  logic         KEY_OP_N,
    input  logic         KEY_GO_N,
    output logic [W-1:0] RESULT,
    output logic         OVF,
    output logic         OP_SUB,
    output logic         BUSY,
    output logic         DONE
);

    state_t       state_r;
    logic [W-1:0] x_r;
    logic [W-1:0] y_r;
    logic         op_r;
    logic         mode_r;
    logic [W:0]   acc_r;
    logic [W:0]   b_r;
    logic [W-1:0] result_r;
    logic         ovf_r;
    logic         op_sub_r;
    logic         busy_r;
    logic         done_r;

    logic         op_press_s;
    logic         go_press_s;
    logic [W-1:0] carry_s;
    logic [W:0]   sum_s;
    logic [W:0]   acc_next_s;
    logic [W:0]   b_next_s;
    logic         ovf_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_op (
        .clk   (CLK),
        .rst_n (RST_N),
        .key_n (KEY_OP_N),
        .press (op_press_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_go (
        .clk   (CLK),
        .rst_n (RST_N),
        .key_n (KEY_GO_N),
        .press (go_press_s)
    );

    // One carry-propagate step; the carry leaving bit W-1 folds into acc[W].
    assign carry_s    = acc_r[W-1:0] & b_r[W-1:0];
    assign sum_s      = acc_r ^ b_r;
    assign acc_next_s = {sum_s[W] | carry_s[W-1], sum_s[W-1:0]};
    assign b_next_s   = {1'b0, carry_s[W-2:0], 1'b0};

    // Overflow for the latched operation, evaluated on the final accumulator.
    always_comb begin
        ovf_s = 1'b0;
        case ({mode_r, op_r})
            {1'b0, ADDSUB_OP_ADD}: ovf_s = acc_r[W];
            {1'b0, ADDSUB_OP_SUB}: ovf_s = (x_r < y_r);
            {1'b1, ADDSUB_OP_ADD}: ovf_s = (x_r[W-1] == y_r[W-1]) && (acc_r[W-1] != x_r[W-1]);
            {1'b1, ADDSUB_OP_SUB}: ovf_s = (x_r[W-1] != y_r[W-1]) && (acc_r[W-1] != x_r[W-1]);
            default:               ovf_s = 1'b0;
        endcase
    end

    // Sequencer FSM with operand latch, iteration datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= ST_IDLE;
            x_r      <= {W{1'b0}};
            y_r      <= {W{1'b0}};
            op_r     <= ADDSUB_OP_ADD;
            mode_r   <= 1'b0;
            acc_r    <= {(W+1){1'b0}};
            b_r      <= {(W+1){1'b0}};
            result_r <= {W{1'b0}};
            ovf_r    <= 1'b0;
            op_sub_r <= ADDSUB_OP_ADD;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            // The toggle lands one cycle before LOAD samples it, so a
            // simultaneous OP+GO runs with the new operation.
            if (op_press_s) begin
                op_sub_r <= ~op_sub_r;
            end
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (go_press_s) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    x_r    <= X;
                    y_r    <= Y;
                    op_r   <= op_sub_r;
                    mode_r <= MODE;
                    acc_r  <= {1'b0, X};
                    if (op_sub_r == ADDSUB_OP_SUB) begin
                        b_r <= {1'b0, ~Y} + {{W{1'b0}}, 1'b1};
                    end else begin
                        b_r <= {1'b0, Y};
                    end
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    if (b_r[W-1:0] == {W{1'b0}}) begin
                        result_r <= ovf_s ? {W{1'b1}} : acc_r[W-1:0];
                        ovf_r    <= ovf_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        acc_r <= acc_next_s;
                        b_r   <= b_next_s;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign RESULT = result_r;
    assign OVF    = ovf_r;
    assign OP_SUB = op_sub_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;

endmodule
